// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: PC register, single-outstanding imem handshake,
// one-entry response holding buffer and IF/ID register. Define FETCH_PERF_EN for perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusyF,
  output logic [31:0] FetchCountF,
  output logic [31:0] BubbleCountF
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, target;
  logic [31:0] hold_instr_q, hold_pc_q;
  logic        hold_valid_q, hold_valid_d;
  logic        redirect, resp, ifid_load, bypass, hold_fill, hold_drain, grant;

  always_comb begin
    redirect     = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    target       = (PCSrcE == 2'b10) ? ALUResultE : PCTargetE;
    resp         = (state_q == S_WAIT) && ImemRvalid;
    ifid_load    = !FlushD && !StallD;
    bypass       = resp && ifid_load && !hold_valid_q;
    hold_fill    = resp && !bypass && !redirect;
    hold_drain   = hold_valid_q && ifid_load;
    hold_valid_d = !redirect && (hold_fill || (hold_valid_q && !hold_drain));
    ImemReq      = !rst && !StallF && !hold_valid_d && ((state_q == S_ISSUE) || resp);
    grant        = ImemReq && ImemGnt;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_ISSUE: if (grant) state_d = S_WAIT;
      S_WAIT:  if (ImemRvalid) state_d = grant ? S_WAIT : S_ISSUE;
      S_DROP:  if (ImemRvalid) state_d = S_ISSUE;
      default: state_d = S_ISSUE;
    endcase
    // A redirect leaves a stale response in flight only if one is still owed after
    // this cycle; a response consumed this cycle must not park the FSM in DROP.
    if (redirect) begin
      pc_d = target;
      if (grant || ((state_q != S_ISSUE) && !ImemRvalid)) state_d = S_DROP;
    end else if (grant) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      InstrD       <= NOP_INSTR;
      PCD          <= '0;
      PCPlus4D     <= '0;
      ValidD       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      if (grant) req_pc_q <= pc_q;
      if (hold_fill) begin
        hold_instr_q <= ImemRdata;
        hold_pc_q    <= req_pc_q;
      end
      if (FlushD) begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (!StallD) begin
        if (hold_valid_q) begin
          InstrD   <= hold_instr_q;
          PCD      <= hold_pc_q;
          PCPlus4D <= hold_pc_q + 32'd4;
          ValidD   <= 1'b1;
        end else if (bypass) begin
          InstrD   <= ImemRdata;
          PCD      <= req_pc_q;
          PCPlus4D <= req_pc_q + 32'd4;
          ValidD   <= 1'b1;
        end else begin
          InstrD   <= NOP_INSTR;
          PCD      <= '0;
          PCPlus4D <= '0;
          ValidD   <= 1'b0;
        end
      end
    end
  end

  assign ImemAddr   = pc_q;
  assign FetchBusyF = !(hold_valid_q || resp);

`ifdef FETCH_PERF_EN
  logic ifid_any_load, deliver;
  always_comb begin
    ifid_any_load = FlushD || !StallD;
    deliver       = hold_drain || bypass;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCountF  <= '0;
      BubbleCountF <= '0;
    end else if (ifid_any_load) begin
      if (deliver) FetchCountF  <= FetchCountF + 32'd1;
      else         BubbleCountF <= BubbleCountF + 32'd1;
    end
  end
`else
  assign FetchCountF  = '0;
  assign BubbleCountF = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stalls/redirects/memory latency,
// checked against a program-order model of the delivered instruction stream.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, StallF = 1'b1, StallD = 1'b0, FlushD = 1'b0;
  logic [1:0]  PCSrcE = 2'b00;
  logic [31:0] PCTargetE = '0, ALUResultE = '0;
  logic        ImemReq, ImemGnt, ValidD, FetchBusyF;
  logic        ImemRvalid = 1'b0;
  logic [31:0] ImemRdata = '0;
  logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D, FetchCountF, BubbleCountF;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
    .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchBusyF(FetchBusyF), .FetchCountF(FetchCountF), .BubbleCountF(BubbleCountF)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // Instruction memory: grant after gnt_delay waiting cycles, data rd_lat cycles after grant.
  int unsigned gnt_delay = 0, rd_lat = 1, gnt_wait = 0, pend_cnt = 0;
  logic        pend = 1'b0, overlap_seen = 1'b0;
  logic [31:0] pend_addr = '0;

  assign ImemGnt = ImemReq && (gnt_wait >= gnt_delay);

  always @(posedge clk) begin
    ImemRvalid <= 1'b0;
    gnt_wait   <= (ImemReq && !ImemGnt) ? gnt_wait + 1 : 0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        ImemRvalid <= 1'b1;
        ImemRdata  <= word_at(pend_addr);
        pend       <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (ImemReq && ImemGnt) begin
      if (pend) overlap_seen <= 1'b1;
      if (rd_lat <= 1) begin
        ImemRvalid <= 1'b1;
        ImemRdata  <= word_at(ImemAddr);
      end else begin
        pend      <= 1'b1;
        pend_addr <= ImemAddr;
        pend_cnt  <= rd_lat - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: next PC expected in program order, plus expected perf counts.
  logic [31:0] exp_pc = RESET_PC;
  int unsigned fexp = 0, bexp = 0;
  logic [31:0] l_instr = '0, l_pc = '0, l_pc4 = '0;
  logic        l_valid = 1'b0;

  task automatic cycle();
    logic p_rst, p_stall, p_flush, p_busy, p_redir, ld;
    logic [31:0] p_tgt;
    #1;
    p_rst   = rst;
    p_stall = StallD;
    p_flush = FlushD;
    p_busy  = FetchBusyF;
    p_redir = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    p_tgt   = (PCSrcE == 2'b10) ? ALUResultE : PCTargetE;
    if (rst) chk1("req_in_rst", ImemReq, 1'b0);
    else if (StallF) chk1("req_under_stallf", ImemReq, 1'b0);
    @(posedge clk);
    #1;
    ld = !p_rst && (p_flush || !p_stall);
    if (p_rst) begin
      exp_pc = RESET_PC;
      fexp = 0;
      bexp = 0;
      chk("rst_instr", InstrD, NOP);
      chk("rst_pcd", PCD, 32'h0);
      chk("rst_pc4", PCPlus4D, 32'h0);
      chk1("rst_valid", ValidD, 1'b0);
      chk("rst_addr", ImemAddr, RESET_PC);
      chk1("rst_busy", FetchBusyF, 1'b1);
    end else if (ld) begin
      if (!p_flush) chk1("busy_vs_valid", ValidD, !p_busy);
      if (ValidD === 1'b1) begin
        chk("order_pcd", PCD, exp_pc);
        chk("order_instr", InstrD, word_at(exp_pc));
        chk("order_pc4", PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        fexp++;
      end else begin
        chk("bubble_instr", InstrD, NOP);
        if (p_flush) chk("flush_pcd", PCD, 32'h0);
        bexp++;
      end
    end else begin
      chk("stall_instr", InstrD, l_instr);
      chk("stall_pcd", PCD, l_pc);
      chk("stall_pc4", PCPlus4D, l_pc4);
      chk1("stall_valid", ValidD, l_valid);
    end
    if (!p_rst && p_redir) exp_pc = p_tgt;
`ifdef FETCH_PERF_EN
    chk("fetch_count", FetchCountF, fexp);
    chk("bubble_count", BubbleCountF, bexp);
`else
    chk("fetch_count_tied", FetchCountF, 32'h0);
    chk("bubble_count_tied", BubbleCountF, 32'h0);
`endif
    l_instr = InstrD;
    l_pc    = PCD;
    l_pc4   = PCPlus4D;
    l_valid = ValidD;
  endtask

  task automatic do_reset();
    StallF = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
    gnt_delay = 0; rd_lat = 1;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    StallF = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    // Zero-wait memory: sequential addresses, first valid two cycles after reset.
    do_reset();
    chk("zw_addr0", ImemAddr, 32'h0);
    cycle();
    chk1("zw_valid_e1", ValidD, 1'b0);
    chk("zw_addr1", ImemAddr, 32'h4);
    cycle();
    chk1("zw_first_valid", ValidD, 1'b1);
    chk("zw_first_pcd", PCD, 32'h0);
    for (int k = 3; k < 10; k++) begin
      cycle();
      chk("zw_addr", ImemAddr, 32'(4 * k));
      chk("zw_pcd", PCD, 32'(4 * (k - 2)));
    end

    // Grant delayed 3 cycles at address 0x8.
    do_reset();
    cycle();
    cycle();
    gnt_delay = 3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk1("gd_req", ImemReq, 1'b1);
      chk("gd_addr", ImemAddr, 32'h8);
      chk1("gd_busy", FetchBusyF, 1'b1);
      if (k > 0) chk1("gd_bubble", ValidD, 1'b0);
    end
    gnt_delay = 0;
    cycle();
    chk1("gd_bubble_last", ValidD, 1'b0);
    cycle();
    chk1("gd_valid", ValidD, 1'b1);
    chk("gd_pcd", PCD, 32'h8);

    // StallD while the 0xC response returns: captured in the holding buffer.
    do_reset();
    repeat (4) cycle();
    StallD = 1'b1;
    #1 chk1("hold_noreq0", ImemReq, 1'b0);
    cycle();
    #1 chk1("hold_noreq1", ImemReq, 1'b0);
    chk1("hold_busy", FetchBusyF, 1'b0);
    cycle();
    StallD = 1'b0;
    #1 chk1("hold_drain_req", ImemReq, 1'b1);
    chk("hold_drain_addr", ImemAddr, 32'h10);
    cycle();
    chk("hold_pcd_c", PCD, 32'hC);
    chk1("hold_valid_c", ValidD, 1'b1);
    cycle();
    chk("hold_pcd_10", PCD, 32'h10);

    // Branch redirect to 0x100 while the 0x20 request is outstanding.
    do_reset();
    for (int k = 0; k < 20 && ImemAddr !== 32'h20; k++) cycle();
    chk("br_reach_20", ImemAddr, 32'h20);
    rd_lat = 3;
    cycle();
    rd_lat = 1;
    PCSrcE = 2'b01; PCTargetE = 32'h100;
    #1 chk1("br_wait_noreq", ImemReq, 1'b0);
    cycle();
    PCSrcE = 2'b00;
    chk("br_pcf", ImemAddr, 32'h100);
    chk1("br_bubble", ValidD, 1'b0);
    #1 chk1("br_drop_noreq0", ImemReq, 1'b0);
    cycle();
    #1 chk1("br_drop_noreq1", ImemReq, 1'b0);
    cycle();
    #1 chk1("br_target_req", ImemReq, 1'b1);
    chk("br_target_addr", ImemAddr, 32'h100);
    for (int k = 0; k < 8 && ValidD !== 1'b1; k++) cycle();
    chk("br_target_pcd", PCD, 32'h100);

    // jalr redirect with FlushD and StallF together.
    PCSrcE = 2'b10; ALUResultE = 32'h40; FlushD = 1'b1; StallF = 1'b1;
    cycle();
    PCSrcE = 2'b00; FlushD = 1'b0; StallF = 1'b0;
    chk("jalr_pcf", ImemAddr, 32'h40);
    chk1("jalr_valid", ValidD, 1'b0);
    chk("jalr_instr", InstrD, NOP);
    for (int k = 0; k < 8 && ValidD !== 1'b1; k++) cycle();
    chk("jalr_target_pcd", PCD, 32'h40);

    // Reset while WAIT; the late response must be ignored.
    do_reset();
    rd_lat = 3;
    cycle();
    rst = 1'b1; StallF = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk1("late_rv_busy", FetchBusyF, 1'b1);
    cycle();
    chk1("late_rv_valid", ValidD, 1'b0);
    chk("late_rv_addr", ImemAddr, RESET_PC);
    StallF = 1'b0; rd_lat = 1;
    for (int k = 0; k < 8 && ValidD !== 1'b1; k++) cycle();
    chk("after_rst_pcd", PCD, RESET_PC);

    // Randomized stalls, flushes, redirects and memory timing.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      gnt_delay = $urandom_range(0, 2);
      rd_lat    = $urandom_range(1, 3);
      StallF    = ($urandom_range(0, 99) < 20);
      StallD    = ($urandom_range(0, 99) < 20);
      FlushD    = ($urandom_range(0, 99) < 5);
      PCTargetE  = $urandom() & 32'hFFFF_FFFC;
      ALUResultE = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      PCSrcE = 2'b00;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        PCSrcE = 2'b01; FlushD = 1'b1;
      end else if (r < 8) begin
        PCSrcE = 2'b10; FlushD = 1'b1;
      end else if (r < 11) begin
        PCSrcE = 2'b11;
      end
      cycle();
    end
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
    gnt_delay = 0; rd_lat = 1;
    repeat (10) cycle();
    chk1("random_progress", fexp > 200, 1'b1);
    chk1("one_outstanding", overlap_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
